// File: rtl/l2_axis_pack64.sv
// AXI-Stream width packer: two 32-bit vector elements per 64-bit output beat.
// Odd-length vectors close with a padded upper lane; tlast is carried one-for-one.
module l2_axis_pack64 #(
  parameter logic [31:0] PAD_VALUE = 32'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      io_in_tdata,
  input  logic             io_in_tvalid,
  output logic             io_in_tready,
  input  logic             io_in_tlast,
  output logic [63:0]      io_out_tdata,
  output logic             io_out_tvalid,
  input  logic             io_out_tready,
  output logic             io_out_tlast,
  output logic [7:0]       io_out_tkeep,
  output logic             io_out_tuser,
  output logic [CNT_W-1:0] io_pkt_count
);

  localparam int unsigned ELEM_W = 32;
  localparam int unsigned BEAT_W = 2 * ELEM_W;
  localparam int unsigned KEEP_W = BEAT_W / 8;

  localparam logic [KEEP_W-1:0] KEEP_FULL = KEEP_W'(8'hFF);
  localparam logic [KEEP_W-1:0] KEEP_HALF = KEEP_W'(8'h0F);

  typedef enum logic {
    LO_EMPTY = 1'b0,
    LO_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   lo_q, lo_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

  logic in_ready;
  logic in_fire;
  logic out_fire;

  // The single output slot frees in the same cycle it drains, so no bubble.
  assign in_ready = !out_valid_q || io_out_tready;
  assign in_fire  = io_in_tvalid && in_ready;
  assign out_fire = out_valid_q && io_out_tready;

  // Next-state and output-slot load; a load in the drain cycle wins over the clear.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q && !out_fire;
    pkt_cnt_d   = pkt_cnt_q;

    if (out_fire && out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end

    case (state_q)
      LO_EMPTY: begin
        if (in_fire) begin
          if (io_in_tlast) begin
            out_data_d  = {PAD_VALUE, io_in_tdata};
            out_keep_d  = KEEP_HALF;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            lo_d    = io_in_tdata;
            state_d = LO_FULL;
          end
        end
      end
      LO_FULL: begin
        if (in_fire) begin
          out_data_d  = {io_in_tdata, lo_q};
          out_keep_d  = KEEP_FULL;
          out_last_d  = io_in_tlast;
          out_valid_d = 1'b1;
          state_d     = LO_EMPTY;
        end
      end
      default: begin
        state_d = LO_EMPTY;
      end
    endcase
  end

  // State and output registers; reset drops any half-packed element.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LO_EMPTY;
      lo_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_keep_q  <= out_keep_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign io_in_tready  = in_ready;
  assign io_out_tdata  = out_data_q;
  assign io_out_tvalid = out_valid_q;
  assign io_out_tlast  = out_last_q;
  assign io_out_tkeep  = out_keep_q;
  assign io_out_tuser  = 1'b0;
  assign io_pkt_count  = pkt_cnt_q;

endmodule

// File: tb/tb_l2_axis_pack64.sv
// Directed bench for l2_axis_pack64: hand-computed beats plus an element-pairing scoreboard.
module tb_l2_axis_pack64;

  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] PAD   = 32'hA5A5_0000;

  logic             clock;
  logic             reset;
  logic [31:0]      io_in_tdata;
  logic             io_in_tvalid;
  logic             io_in_tready;
  logic             io_in_tlast;
  logic [63:0]      io_out_tdata;
  logic             io_out_tvalid;
  logic             io_out_tready;
  logic             io_out_tlast;
  logic [7:0]       io_out_tkeep;
  logic             io_out_tuser;
  logic [CNT_W-1:0] io_pkt_count;

  l2_axis_pack64 #(.PAD_VALUE(PAD), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_tdata   (io_in_tdata),
    .io_in_tvalid  (io_in_tvalid),
    .io_in_tready  (io_in_tready),
    .io_in_tlast   (io_in_tlast),
    .io_out_tdata  (io_out_tdata),
    .io_out_tvalid (io_out_tvalid),
    .io_out_tready (io_out_tready),
    .io_out_tlast  (io_out_tlast),
    .io_out_tkeep  (io_out_tkeep),
    .io_out_tuser  (io_out_tuser),
    .io_pkt_count  (io_pkt_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  logic [72:0] obs_q[$];
  logic [72:0] exp_q[$];
  logic        mdl_have_lo;
  logic [31:0] mdl_lo;

  logic        prev_stall;
  logic [72:0] prev_beat;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] beat(input logic last, input logic [7:0] keep, input logic [63:0] data);
    return {last, keep, data};
  endfunction

  // Downstream ready generator
  initial begin
    io_out_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       io_out_tready = 1'b1;
        1:       io_out_tready = 1'($urandom_range(0, 1));
        default: io_out_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: logs handshakes and checks hold-stability during stalls
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_eq("stall_hold", {io_out_tlast, io_out_tkeep, io_out_tdata}, prev_beat);
      if (io_out_tvalid && io_out_tready)
        obs_q.push_back({io_out_tlast, io_out_tkeep, io_out_tdata});
      prev_stall = io_out_tvalid && !io_out_tready;
      prev_beat  = {io_out_tlast, io_out_tkeep, io_out_tdata};
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit ok;
    ok = 0;
    io_in_tdata  = d;
    io_in_tlast  = l;
    io_in_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (io_in_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clock);
    #1;
    if (!ok) check_eq("in_timeout", 73'(0), 73'(1));
    if (!mdl_have_lo) begin
      if (l) exp_q.push_back(beat(1'b1, 8'h0F, {PAD, d}));
      else begin
        mdl_lo      = d;
        mdl_have_lo = 1'b1;
      end
    end else begin
      exp_q.push_back(beat(l, 8'hFF, {d, mdl_lo}));
      mdl_have_lo = 1'b0;
    end
  endtask

  task automatic send_vec(input logic [31:0] first, input int len);
    for (int i = 0; i < len; i++) send_beat(first + 32'(i), i == len - 1);
    io_in_tvalid = 1'b0;
    io_in_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      #2;
      if (obs_q.size() == exp_q.size() && !io_out_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", 73'(0), 73'(1));
  endtask

  task automatic compare_sb(input string tag);
    int n;
    check_eq({tag, "_nbeats"}, 73'(obs_q.size()), 73'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_beat"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    io_in_tvalid = 1'b0;
    io_in_tlast  = 1'b0;
    io_in_tdata  = '0;
    reset        = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset       = 1'b1;
    mdl_have_lo = 1'b0;
    obs_q.delete();
    exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    prev_stall = 1'b0;
    prev_beat  = '0;
    mdl_have_lo = 1'b0;
    mdl_lo = '0;
    io_in_tvalid = 1'b0;
    io_in_tlast  = 1'b0;
    io_in_tdata  = '0;
    reset = 1'b0;
    #12;
    check_eq("rst_tvalid", 73'(io_out_tvalid), 73'(0));
    check_eq("rst_tdata", 73'(io_out_tdata), 73'(0));
    check_eq("rst_tkeep", 73'(io_out_tkeep), 73'(0));
    check_eq("rst_tlast", 73'(io_out_tlast), 73'(0));
    check_eq("rst_count", 73'(io_pkt_count), 73'(0));
    check_eq("rst_in_tready", 73'(io_in_tready), 73'(1));
    do_reset();

    // T1: even vector {1,2,3,4}
    send_vec(32'd1, 4);
    wait_drain();
    check_eq("t1_beat0", obs_q[0], beat(1'b0, 8'hFF, 64'h00000002_00000001));
    check_eq("t1_beat1", obs_q[1], beat(1'b1, 8'hFF, 64'h00000004_00000003));
    check_eq("t1_count", 73'(io_pkt_count), 73'(1));
    check_eq("t1_tuser", 73'(io_out_tuser), 73'(0));
    compare_sb("t1");

    // T2: odd vector {5,6,7}
    send_vec(32'd5, 3);
    wait_drain();
    check_eq("t2_beat0", obs_q[0], beat(1'b0, 8'hFF, 64'h00000006_00000005));
    check_eq("t2_beat1", obs_q[1], beat(1'b1, 8'h0F, 64'hA5A50000_00000007));
    check_eq("t2_count", 73'(io_pkt_count), 73'(2));
    compare_sb("t2");

    // T3: single element, output valid one cycle after accept
    check_eq("t3_idle", 73'(io_out_tvalid), 73'(0));
    send_beat(32'd9, 1'b1);
    io_in_tvalid = 1'b0;
    io_in_tlast  = 1'b0;
    check_eq("t3_valid", 73'(io_out_tvalid), 73'(1));
    check_eq("t3_data", beat(io_out_tlast, io_out_tkeep, io_out_tdata),
             beat(1'b1, 8'h0F, 64'hA5A50000_00000009));
    wait_drain();
    check_eq("t3_count", 73'(io_pkt_count), 73'(3));
    compare_sb("t3");

    // T4: downstream stall while streaming
    rdy_mode = 2;
    repeat (2) @(posedge clock);
    #1;
    fork
      send_vec(32'd10, 6);
      begin
        repeat (12) @(posedge clock);
        @(negedge clock);
        check_eq("t4_in_tready", 73'(io_in_tready), 73'(0));
        check_eq("t4_out_tvalid", 73'(io_out_tvalid), 73'(1));
        rdy_mode = 0;
      end
    join
    wait_drain();
    check_eq("t4_count", 73'(io_pkt_count), 73'(4));
    compare_sb("t4");

    // T5: reset mid-vector discards the half-packed element
    send_beat(32'd1, 1'b0);
    io_in_tvalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_tdata", 73'(io_out_tdata), 73'(0));
    check_eq("t5_tvalid", 73'(io_out_tvalid), 73'(0));
    check_eq("t5_tkeep", 73'(io_out_tkeep), 73'(0));
    check_eq("t5_count", 73'(io_pkt_count), 73'(0));
    @(negedge clock);
    reset = 1'b1;
    mdl_have_lo = 1'b0;
    obs_q.delete();
    exp_q.delete();
    @(posedge clock);
    #1;
    send_vec(32'd3, 2);
    wait_drain();
    check_eq("t5_beat0", obs_q[0], beat(1'b1, 8'hFF, 64'h00000004_00000003));
    check_eq("t5_count_after", 73'(io_pkt_count), 73'(1));
    compare_sb("t5");

    // T6: 2^CNT_W+2 back-to-back packets, random downstream ready
    do_reset();
    rdy_mode = 1;
    for (int p = 0; p < (1 << CNT_W) + 2; p++) begin
      for (int i = 0; i < (p % 4) + 1; i++)
        send_beat(32'(p * 256 + i), i == (p % 4));
    end
    io_in_tvalid = 1'b0;
    io_in_tlast  = 1'b0;
    rdy_mode = 0;
    wait_drain();
    check_eq("t6_count_wrap", 73'(io_pkt_count), 73'(2));
    compare_sb("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
